// File: rtl/axis_pgen_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern source.
// Holds FSM/pattern enums, the colour-bar table and a width helper.
package axis_pgen_pkg;

    typedef enum logic [1:0] {IDLE, VBL, LINE, HBL} pgen_state_e;

    typedef enum logic [1:0] {P_HRAMP, P_DIAG, P_BARS, P_SOLID} pattern_e;

    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Bits needed to hold 0..max; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/axis_pgen_pixel.sv
// Registered pattern-to-tdata mapper for axis_video_pattern_gen.
// Fed with next-cycle x/y so tdata lines up with the registered tvalid.
module axis_pgen_pixel
    import axis_pgen_pkg::*;
#(
    parameter int DSIZE   = 24,
    parameter int HACTIVE = 1920,
    parameter int XW      = 11,
    parameter int YW      = 11
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [XW-1:0]    x_i,
    input  logic [YW-1:0]    y_i,
    input  pattern_e         pattern_i,
    input  logic [DSIZE-1:0] solid_i,
    output logic [DSIZE-1:0] tdata_o
);

    localparam int BAR_W = (HACTIVE >= 8) ? HACTIVE / 8 : 1;

    logic [DSIZE-1:0] tdata_q, tdata_d;
    logic [31:0]      bar_q32;
    logic [2:0]       bar_idx;

    // Bar index is the x position divided by bar width, clamped to the last bar.
    always_comb begin
        bar_q32 = 32'(x_i) / 32'(BAR_W);
        bar_idx = (bar_q32 > 32'd7) ? 3'd7 : bar_q32[2:0];
    end

    // Select the pattern value; all results are fitted to DSIZE bits.
    always_comb begin
        tdata_d = '0;
        unique case (pattern_i)
            P_HRAMP: tdata_d = DSIZE'(x_i);
            P_DIAG:  tdata_d = DSIZE'(x_i) + DSIZE'(y_i);
            P_BARS:  tdata_d = DSIZE'(BAR_COLOURS[bar_idx]);
            P_SOLID: tdata_d = solid_i;
        endcase
    end

    // Output register for tdata.
    always_ff @(posedge clock) begin
        if (rst) begin
            tdata_q <= '0;
        end else begin
            tdata_q <= tdata_d;
        end
    end

    assign tdata_o = tdata_q;

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source with line/frame blanking.
// Optional macro AXIS_PGEN_STALL_STATS_EN adds per-frame stall counters.
module axis_video_pattern_gen
    import axis_pgen_pkg::*;
#(
    parameter int DSIZE   = 24,
    parameter int HACTIVE = 1920,
    parameter int VACTIVE = 1080,
    parameter int HBLANK  = 280,
    parameter int VBLANK  = 45
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [1:0]       pattern_sel_i,
    input  logic [DSIZE-1:0] solid_value_i,
    output logic [DSIZE-1:0] axis_tdata_o,
    output logic             axis_tvalid_o,
    input  logic             axis_tready_i,
    output logic             axis_tuser_o,
    output logic             axis_tlast_o,
    output logic [15:0]      frame_cnt_o,
    output logic             busy_o
`ifdef AXIS_PGEN_STALL_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      last_frame_stall_o
`endif
);

    localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int XW   = cnt_width(HACTIVE - 1);
    localparam int YW   = cnt_width(VACTIVE - 1);
    localparam int CW   = cnt_width(BMAX - 1);

    localparam logic [XW-1:0] X_LAST = XW'(HACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VACTIVE - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HBLANK - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VBLANK - 1);

    pgen_state_e      state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    pattern_e         pat_q, pat_d;
    logic [DSIZE-1:0] solid_q, solid_d;
    logic             tvalid_q, tvalid_d;
    logic             tuser_q, tuser_d;
    logic             tlast_q, tlast_d;
    logic             busy_q, busy_d;
    logic             hs, line_end, launch, frame_done;

    // Next-state logic: blanking counters, x/y walk and frame sequencing.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        hs          = tvalid_q & axis_tready_i;
        line_end    = 1'b0;
        launch      = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable_i) launch = 1'b1;
            end
            VBL: begin
                if (cnt_q == V_LAST) begin
                    cnt_d   = '0;
                    state_d = LINE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LINE: begin
                if (hs) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (HBLANK == 0) line_end = 1'b1;
                        else             state_d  = HBL;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            HBL: begin
                if (cnt_q == H_LAST) begin
                    cnt_d    = '0;
                    line_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        if (line_end) begin
            if (y_q == Y_LAST) begin
                y_d         = '0;
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (enable_i) launch  = 1'b1;
                else          state_d = IDLE;
            end else begin
                y_d     = y_q + YW'(1);
                state_d = LINE;
            end
        end

        // Pattern inputs are only sampled at a frame start.
        if (launch) begin
            pat_d   = pattern_e'(pattern_sel_i);
            solid_d = solid_value_i;
            cnt_d   = '0;
            state_d = (VBLANK == 0) ? LINE : VBL;
        end

        tvalid_d = (state_d == LINE);
        tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
        tlast_d  = tvalid_d && (x_d == X_LAST);
        busy_d   = (state_d != IDLE);
    end

    // FSM and registered stream outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            pat_q       <= P_HRAMP;
            solid_q     <= '0;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
            tvalid_q    <= tvalid_d;
            tuser_q     <= tuser_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
        end
    end

    axis_pgen_pixel #(
        .DSIZE   (DSIZE),
        .HACTIVE (HACTIVE),
        .XW      (XW),
        .YW      (YW)
    ) u_pixel (
        .clock     (clock),
        .rst       (rst),
        .x_i       (x_d),
        .y_i       (y_d),
        .pattern_i (pat_d),
        .solid_i   (solid_d),
        .tdata_o   (axis_tdata_o)
    );

    assign axis_tvalid_o = tvalid_q;
    assign axis_tuser_o  = tuser_q;
    assign axis_tlast_o  = tlast_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = busy_q;

`ifdef AXIS_PGEN_STALL_STATS_EN
    logic [31:0] stall_q, last_stall_q;

    // Saturating stall counter, snapshotted and cleared at frame done.
    always_ff @(posedge clock) begin
        if (rst) begin
            stall_q      <= '0;
            last_stall_q <= '0;
        end else if (frame_done) begin
            last_stall_q <= stall_q;
            stall_q      <= '0;
        end else if (tvalid_q && !axis_tready_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o        = stall_q;
    assign last_frame_stall_o = last_stall_q;
`endif

endmodule
